// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32 opcodes, 4-bit class codes, sequencer states, packet type.
package decode_pkg;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [3:0] CLS_NONE    = 4'd0;
   localparam logic [3:0] CLS_R       = 4'd1;
   localparam logic [3:0] CLS_I_ALU   = 4'd2;
   localparam logic [3:0] CLS_LOAD    = 4'd3;
   localparam logic [3:0] CLS_STORE   = 4'd4;
   localparam logic [3:0] CLS_BRANCH  = 4'd5;
   localparam logic [3:0] CLS_JAL     = 4'd6;
   localparam logic [3:0] CLS_JALR    = 4'd7;
   localparam logic [3:0] CLS_LUI     = 4'd8;
   localparam logic [3:0] CLS_AUIPC   = 4'd9;
   localparam logic [3:0] CLS_FENCE   = 4'd10;
   localparam logic [3:0] CLS_SYSTEM  = 4'd11;
   localparam logic [3:0] CLS_ILLEGAL = 4'd12;

   typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2} state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [3:0]  cls;
      logic        ill;
   } pkt_t;
endpackage

// File: rtl/decode_issue_ctrl_imm_class_decode.sv
// Combinational instr -> {immediate, class, illegal} mapping for RV32 base opcodes.
module imm_class_decode
   import decode_pkg::*;
(
   input  logic [31:0] instr,
   output logic [31:0] imm,
   output logic [3:0]  cls,
   output logic        illegal
);
   logic [31:0] imm_i;
   logic [2:0]  funct3;

   assign funct3 = instr[14:12];
   assign imm_i  = {{20{instr[31]}}, instr[31:20]};

   always_comb begin
      imm     = '0;
      cls     = CLS_ILLEGAL;
      illegal = 1'b0;
      unique case (instr[6:0])
         OPC_OP_IMM: begin
            cls = CLS_I_ALU;
            // shifts carry funct7 in [31:25]; only the shamt is the immediate
            imm = (funct3 == 3'b001 || funct3 == 3'b101) ? {27'b0, instr[24:20]} : imm_i;
         end
         OPC_LOAD:     begin cls = CLS_LOAD;  imm = imm_i; end
         OPC_MISC_MEM: begin cls = CLS_FENCE; imm = imm_i; end
         OPC_JALR:     begin cls = CLS_JALR;  imm = imm_i; end
         OPC_STORE: begin
            cls = CLS_STORE;
            imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         OPC_BRANCH: begin
            cls = CLS_BRANCH;
            imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         OPC_LUI:   begin cls = CLS_LUI;   imm = {instr[31:12], 12'b0}; end
         OPC_AUIPC: begin cls = CLS_AUIPC; imm = {instr[31:12], 12'b0}; end
         OPC_JAL: begin
            cls = CLS_JAL;
            imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         OPC_OP:     cls = CLS_R;
         OPC_SYSTEM: cls = CLS_SYSTEM;
         default: begin
            cls     = CLS_ILLEGAL;
            illegal = 1'b1;
         end
      endcase
   end
endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-stage sequencer: 2-entry skid buffer (output reg + skid reg) with flush and decode.
// Optional perf counters enabled with `define DECODE_PERF_CNT_EN.
module decode_issue_ctrl
   import decode_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter bit FLUSH_DRAIN = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_imm,
   output logic [3:0]      out_class,
   output logic            out_illegal,
   input  logic            flush
`ifdef DECODE_PERF_CNT_EN
   ,
   output logic [31:0]     perf_issued,
   output logic [31:0]     perf_stall,
   output logic [31:0]     perf_illegal
`endif
);
   pkt_t   in_pkt, out_q, out_d, skid_q, skid_d;
   state_e state_q, state_d;
   logic   out_valid_q, out_valid_d, in_ready_q, in_ready_d;
   logic   in_xfer, out_xfer;

   imm_class_decode u_dec (
      .instr   (in_instr),
      .imm     (in_pkt.imm),
      .cls     (in_pkt.cls),
      .illegal (in_pkt.ill)
   );
   assign in_pkt.instr = in_instr;
   assign in_pkt.pc    = in_pc;

   assign in_xfer  = in_valid && in_ready_q;
   assign out_xfer = out_valid_q && out_ready;

   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      skid_d      = skid_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         ST_EMPTY: if (in_xfer) begin
            out_d = in_pkt; out_valid_d = 1'b1; state_d = ST_ONE;
         end
         ST_ONE: begin
            if (in_xfer && out_xfer) out_d = in_pkt;
            else if (in_xfer) begin
               skid_d = in_pkt; state_d = ST_TWO;
            end else if (out_xfer) begin
               out_valid_d = 1'b0; state_d = ST_EMPTY;
            end
         end
         ST_TWO: if (out_xfer) begin
            out_d = skid_q; state_d = ST_ONE;
         end
         default: state_d = ST_EMPTY;
      endcase
      in_ready_d = (state_d != ST_TWO);
      // flush wins over any concurrent input; the dropped word is never decoded into state
      if (flush) begin
         state_d     = ST_EMPTY;
         out_valid_d = 1'b0;
         in_ready_d  = !FLUSH_DRAIN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         out_q       <= '0;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         skid_q      <= skid_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_instr   = out_q.instr;
   assign out_pc      = out_q.pc;
   assign out_imm     = out_q.imm;
   assign out_class   = out_q.cls;
   assign out_illegal = out_q.ill;

`ifdef DECODE_PERF_CNT_EN
   logic [31:0] perf_issued_q, perf_issued_d, perf_stall_q, perf_stall_d;
   logic [31:0] perf_illegal_q, perf_illegal_d;

   always_comb begin
      perf_issued_d  = perf_issued_q + {31'b0, out_xfer};
      perf_stall_d   = perf_stall_q + {31'b0, (out_valid_q && !out_ready)};
      perf_illegal_d = perf_illegal_q + {31'b0, (out_xfer && out_q.ill)};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_issued_q  <= '0;
         perf_stall_q   <= '0;
         perf_illegal_q <= '0;
      end else begin
         perf_issued_q  <= perf_issued_d;
         perf_stall_q   <= perf_stall_d;
         perf_illegal_q <= perf_illegal_d;
      end
   end

   assign perf_issued  = perf_issued_q;
   assign perf_stall   = perf_stall_q;
   assign perf_illegal = perf_illegal_q;
`endif
endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl; checks counters too when DECODE_PERF_CNT_EN is defined.
module tb_decode_issue_ctrl;
   logic        clk = 1'b0;
   logic        rst_n, in_valid, out_ready, flush;
   logic        in_ready, out_valid, out_illegal;
   logic [31:0] in_instr, in_pc, out_instr, out_pc, out_imm;
   logic [3:0]  out_class;
`ifdef DECODE_PERF_CNT_EN
   logic [31:0] perf_issued, perf_stall, perf_illegal;
`endif
   int passed = 0;
   int failed = 0;
   int total  = 0;

   decode_issue_ctrl dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .out_imm(out_imm), .out_class(out_class),
      .out_illegal(out_illegal), .flush(flush)
`ifdef DECODE_PERF_CNT_EN
      , .perf_issued(perf_issued), .perf_stall(perf_stall), .perf_illegal(perf_illegal)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] v_instr [8] = '{32'hFFF00093, 32'h00509093, 32'h4030D093, 32'h123450B7,
                                32'hFFDFF06F, 32'hFE112E23, 32'hFE000EE3, 32'h0000007F};
   logic [31:0] v_imm   [8] = '{32'hFFFFFFFF, 32'h00000005, 32'h00000003, 32'h12345000,
                                32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000000};
   logic [3:0]  v_cls   [8] = '{4'd2, 4'd2, 4'd2, 4'd8, 4'd6, 4'd4, 4'd5, 4'd12};

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      in_instr = '0; in_pc = '0;
      #12;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_imm", out_imm, 32'd0);
      chk("rst_out_class", {28'b0, out_class}, 32'd0);
      chk("rst_out_illegal", {31'b0, out_illegal}, 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
`ifdef DECODE_PERF_CNT_EN
      chk("rst_perf_issued", perf_issued, 32'd0);
`endif
      rst_n = 1'b1;
      step();

      // streaming decode, one packet per cycle
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_instr = v_instr[i]; in_pc = 32'h1000 + 32'(4 * i);
         step();
         chk($sformatf("strm%0d_valid", i), {31'b0, out_valid}, 32'd1);
         chk($sformatf("strm%0d_imm", i), out_imm, v_imm[i]);
         chk($sformatf("strm%0d_class", i), {28'b0, out_class}, {28'b0, v_cls[i]});
         chk($sformatf("strm%0d_illegal", i), {31'b0, out_illegal}, (i == 7) ? 32'd1 : 32'd0);
         chk($sformatf("strm%0d_pc", i), out_pc, 32'h1000 + 32'(4 * i));
         chk($sformatf("strm%0d_instr", i), out_instr, v_instr[i]);
      end
      in_valid = 1'b0;
      step();
      chk("strm_drain_valid", {31'b0, out_valid}, 32'd0);

      // backpressure: two entries fill, third is refused, order preserved
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h100;
      step();
      chk("bp_first_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_first_ready", {31'b0, in_ready}, 32'd1);
      in_pc = 32'h104; in_instr = 32'h00509093;
      step();
      chk("bp_two_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_two_pc", out_pc, 32'h100);
      in_pc = 32'h108;
      step();
      chk("bp_hold_pc", out_pc, 32'h100);
      chk("bp_hold_imm", out_imm, 32'hFFFFFFFF);
      chk("bp_hold_ready", {31'b0, in_ready}, 32'd0);
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      chk("bp_second_pc", out_pc, 32'h104);
      chk("bp_second_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_second_ready", {31'b0, in_ready}, 32'd1);
      step();
      chk("bp_empty_valid", {31'b0, out_valid}, 32'd0);

      // flush while full, with a competing input
      out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h200;
      step();
      in_pc = 32'h204;
      step();
      chk("fl2_pre_ready", {31'b0, in_ready}, 32'd0);
      flush = 1'b1; in_pc = 32'h208;
      step();
      chk("fl2_valid", {31'b0, out_valid}, 32'd0);
      chk("fl2_ready", {31'b0, in_ready}, 32'd1);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step();
      chk("fl2_nothing_valid", {31'b0, out_valid}, 32'd0);

      // flush beats an accepted input in state ONE
      out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h300;
      step();
      chk("fl1_pre_valid", {31'b0, out_valid}, 32'd1);
      flush = 1'b1; in_pc = 32'h304;
      step();
      chk("fl1_valid", {31'b0, out_valid}, 32'd0);
      flush = 1'b0; in_valid = 1'b0;
      step();
      chk("fl1_dropped_valid", {31'b0, out_valid}, 32'd0);

`ifdef DECODE_PERF_CNT_EN
      chk("perf_issued", perf_issued, 32'd10);
      chk("perf_stall", perf_stall, 32'd5);
      chk("perf_illegal", perf_illegal, 32'd1);
`endif

      // async reset mid-operation
      in_valid = 1'b1; in_pc = 32'h400;
      step();
      chk("ar_pre_valid", {31'b0, out_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("ar_valid", {31'b0, out_valid}, 32'd0);
      chk("ar_ready", {31'b0, in_ready}, 32'd1);
      chk("ar_pc", out_pc, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
- Decode-stage sequencer between instruction fetch and execute.
- Accepts 32-bit instruction words on a valid/ready handshake and buffers them in a 2-entry skid buffer.
- Expands the immediate and classifies the opcode, then presents a registered decoded packet to execute on a second valid/ready handshake.
- Handles backpressure, pipeline flush on redirect, and illegal-opcode flagging.

Parameters:
- XLEN, 32, datapath and immediate width; only 32 is supported.
- FLUSH_DRAIN, 0; 1 = hold in_ready low for one cycle after a flush.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  block can accept; registered.
- in_instr  input  32  instruction word.
- in_pc  input  32  PC of in_instr.
- out_valid  output  1  decoded packet valid.
- out_ready  input  1  execute accepts the packet.
- out_instr  output  32  instruction, passed through.
- out_pc  output  32  PC, passed through.
- out_imm  output  32  expanded immediate.
- out_class  output  4  instruction class code.
- out_illegal  output  1  opcode is not recognised.
- flush  input  1  kill all buffered and output entries.

Behaviour:
- Reset (async, rst_n low):
  - out_valid=0, in_ready=1, out_imm=0, out_class=CLS_NONE, out_illegal=0, out_instr=0, out_pc=0, FSM=EMPTY.
  - Counters clear.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- FSM states:
  - EMPTY: 0 entries.
  - ONE: output register full.
  - TWO: output register plus skid register full.
- FSM transitions:
  - EMPTY + in xfer -> ONE.
  - ONE + in xfer without out xfer -> TWO.
  - ONE + out xfer without in xfer -> EMPTY.
  - ONE + both -> ONE, with the new packet loaded.
  - TWO + out xfer -> ONE, skid moves to the output register.
  - in_ready = (next state != TWO), registered. No input is accepted in TWO.
- Latency: 1 cycle from input transfer to out_valid when empty. Throughput is 1/cycle under continuous out_ready.
- Ordering: strict FIFO. The skid entry always leaves before any newer instruction.
- Output stability: out_* hold stable while out_valid && !out_ready.
- Decode is computed on the input side and stored with each entry. The sub-module is purely combinational.
- Immediate rules, by opcode [6:0]:
  - 0010011 with funct3 001/101: zero-extend [24:20].
  - Other 0010011, and 0000011, 0001111, 1100111: sign-extend [31:20].
  - 0100011: sign-extend {[31:25],[11:7]}.
  - 1100011: sign-extend {[31],[7],[30:25],[11:8],0}.
  - 0110111 and 0010111: {[31:12],12'b0}.
  - 1101111: sign-extend {[31],[19:12],[20],[30:21],0}.
  - 0110011 and 1110011: imm 0.
- Classes: R, I_ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, FENCE, SYSTEM, ILLEGAL.
  - Any other opcode: class ILLEGAL, out_illegal=1, imm 0, still issued in order.
- Flush:
  - Synchronous. Next cycle out_valid=0 and FSM=EMPTY.
  - Flush has priority over any simultaneous in xfer; the input is dropped.
  - An output transfer in the same cycle still counts as delivered.
  - With FLUSH_DRAIN=1, in_ready=0 for exactly the cycle after flush.
- Reset mid-operation discards all entries immediately.

Optional Feature:
- Macro DECODE_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_issued[31:0], perf_stall[31:0], perf_illegal[31:0].
  - perf_issued increments on each output transfer.
  - perf_stall increments each cycle with out_valid && !out_ready.
  - perf_illegal increments on each issued illegal packet.
  - All three wrap at 2^32, reset to 0, and are unaffected by flush.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package decode_pkg holds:
  - opcode localparams;
  - the 4-bit class encoding (CLS_NONE=0 ... CLS_ILLEGAL=12);
  - FSM state encoding.
- One natural sub-module, imm_class_decode: combinational mapping instr -> {imm, class, illegal}, instantiated once on the input path.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), out_ready=1 -> one cycle later out_valid=1, imm 0xFFFFFFFF, class I_ALU.
- slli 0x00509093 -> imm 0x00000005. srai 0x4030D093 -> imm 0x00000003 (funct7 stripped).
- lui 0x123450B7 -> imm 0x12345000. jal 0xFFDFF06F -> imm 0xFFFFFFFC. sw 0xFE112E23 -> imm 0xFFFFFFFC.
- out_ready=0, push PC 0x100 and 0x104:
  - in_ready falls after the second push;
  - the 0x100 packet stays stable;
  - on out_ready=1, 0x100 then 0x104 issue on consecutive cycles.
- flush asserted with in_valid=1 while in state TWO -> next cycle out_valid=0, nothing issued, in_ready=1.
- Instruction 0x0000007F -> out_illegal=1, class ILLEGAL, imm 0. With DECODE_PERF_CNT_EN, perf_illegal=1.
